// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared states, op codes and width defaults for rf_access_sched
package rf_sched_pkg;
  localparam int RF_DW = 16;
  localparam int RF_AW = 3;
  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ = 1'b1;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, RESP} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; ptr_q remembers the last granted port
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr_q, ptr_d;
  always_comb begin
    grant = &req ? (ptr_q ? 2'b01 : 2'b10) : req;
    ptr_d = (advance && |grant) ? grant[1] : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= 1'b1;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rf_access_sched.sv
// rf_access_sched: serializes two requesters' read-pair/write transactions onto a 1R1W register file
// RF_SCHED_SAMEREG_EN: a read with ra == rb skips RD_B
module rf_access_sched
  import rf_sched_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_ra0,
  input  logic [AW-1:0] req_ra1,
  input  logic [AW-1:0] req_rb0,
  input  logic [AW-1:0] req_rb1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic          rsp_valid,
  output logic          rsp_port,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  output logic [AW-1:0] rf_readnum,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  input  logic [DW-1:0] rf_data_out
);
  state_e state_q, state_d;
  logic port_q, port_d;
  logic [AW-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [DW-1:0] wd_q, wd_d, a_q, a_d, b_q, b_d;
  logic [1:0] grant;
  logic idle, same_reg;
  assign idle = state_q == IDLE;
`ifdef RF_SCHED_SAMEREG_EN
  assign same_reg = ra_q == rb_q;
`else
  assign same_reg = 1'b0;
`endif
  // Arbiter only sees requests in IDLE, so grants (and ready) never occur while busy
  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (idle ? req_valid : 2'b00),
    .advance (idle),
    .grant   (grant)
  );
  always_comb begin
    state_d = state_q;
    port_d = port_q;
    ra_d = ra_q;
    rb_d = rb_q;
    wd_d = wd_q;
    a_d = a_q;
    b_d = b_q;
    req_ready = grant;
    rsp_valid = state_q == RESP;
    rsp_port = state_q == RESP ? port_q : 1'b0;
    rsp_a = state_q == RESP ? a_q : '0;
    rsp_b = state_q == RESP ? b_q : '0;
    rf_readnum = state_q == RD_A ? ra_q : state_q == RD_B ? rb_q : '0;
    rf_write = state_q == WR;
    rf_writenum = state_q == WR ? ra_q : '0;
    rf_data_in = state_q == WR ? wd_q : '0;
    case (state_q)
      IDLE: if (|grant) begin
        port_d = grant[1];
        ra_d = grant[1] ? req_ra1 : req_ra0;
        rb_d = grant[1] ? req_rb1 : req_rb0;
        wd_d = grant[1] ? req_wdata1 : req_wdata0;
        state_d = req_op[grant[1]] == OP_READ ? RD_A : WR;
      end
      RD_A: begin
        a_d = rf_data_out;
        b_d = same_reg ? rf_data_out : b_q;
        state_d = same_reg ? RESP : RD_B;
      end
      RD_B: begin
        b_d = rf_data_out;
        state_d = RESP;
      end
      WR: begin
        a_d = '0;
        b_d = '0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      port_q <= 1'b0;
      ra_q <= '0;
      rb_q <= '0;
      wd_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      wd_q <= wd_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
endmodule

// File: tb/tb_rf_access_sched.sv
// tb_rf_access_sched: directed vectors plus multi-cycle sequences against a behavioural 8x16 register file
module tb_rf_access_sched;
  localparam int DW = 16;
  localparam int AW = 3;
`ifdef RF_SCHED_SAMEREG_EN
  localparam int SAME_LAT = 2;
`else
  localparam int SAME_LAT = 3;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] req_valid = '0, req_op = '0, req_ready;
  logic [AW-1:0] req_ra0 = '0, req_ra1 = '0, req_rb0 = '0, req_rb1 = '0;
  logic [DW-1:0] req_wdata0 = '0, req_wdata1 = '0;
  logic rsp_valid, rsp_port, rf_write;
  logic [DW-1:0] rsp_a, rsp_b, rf_data_in, rf_data_out;
  logic [AW-1:0] rf_readnum, rf_writenum;
  always #5 clk = ~clk;
  rf_access_sched #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_ra0(req_ra0), .req_ra1(req_ra1), .req_rb0(req_rb0), .req_rb1(req_rb1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .rsp_valid(rsp_valid), .rsp_port(rsp_port),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rf_readnum(rf_readnum), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );
  logic [DW-1:0] rf_mem [8];
  assign rf_data_out = rf_mem[rf_readnum];
  always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
  typedef struct {
    logic port;
    logic op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [15:0] wd;
    int lat;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;
  vec_t tab [9];
  int n_pass = 0, n_total = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive(input logic p, input logic op, input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] wd);
    req_valid[p] = 1'b1;
    req_op[p] = op;
    if (p) begin
      req_ra1 = ra; req_rb1 = rb; req_wdata1 = wd;
    end else begin
      req_ra0 = ra; req_rb0 = rb; req_wdata0 = wd;
    end
  endtask
  task automatic wait_ready(input logic p, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_ready[p]) ok = 1;
      else @(negedge clk);
    end
  endtask
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic run(input vec_t v, input string tag);
    bit ok;
    int lat;
    drive(v.port, v.op, v.ra, v.rb, v.wd);
    wait_ready(v.port, ok);
    check({tag, " ready"}, 32'(ok), 1);
    if (!ok) begin
      req_valid[v.port] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[v.port] = 1'b0;
    #1;
    if (v.op == 1'b0) begin
      check({tag, " rf_write"}, 32'(rf_write), 1);
      check({tag, " rf_writenum"}, 32'(rf_writenum), 32'(v.ra));
      check({tag, " rf_data_in"}, 32'(rf_data_in), 32'(v.wd));
    end
    wait_rsp(lat);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " rsp_port"}, 32'(rsp_port), 32'(v.port));
    check({tag, " rsp_a"}, 32'(rsp_a), 32'(v.a));
    check({tag, " rsp_b"}, 32'(rsp_b), 32'(v.b));
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bit ok;
    int lat, g, pulses, first, rsps;
    logic [1:0] seq [6];
    logic drop;
    tab[0] = '{1'b0, 1'b0, 3'd3, 3'd0, 16'hBEEF, 2, 16'h0, 16'h0};
    tab[1] = '{1'b1, 1'b0, 3'd5, 3'd6, 16'h1234, 2, 16'h0, 16'h0};
    tab[2] = '{1'b1, 1'b1, 3'd3, 3'd5, 16'h0, 3, 16'hBEEF, 16'h1234};
    tab[3] = '{1'b0, 1'b1, 3'd5, 3'd3, 16'h0, 3, 16'h1234, 16'hBEEF};
    tab[4] = '{1'b1, 1'b0, 3'd0, 3'd0, 16'hA5A5, 2, 16'h0, 16'h0};
    tab[5] = '{1'b0, 1'b1, 3'd0, 3'd3, 16'h0, 3, 16'hA5A5, 16'hBEEF};
    tab[6] = '{1'b0, 1'b1, 3'd3, 3'd3, 16'h0, SAME_LAT, 16'hBEEF, 16'hBEEF};
    tab[7] = '{1'b1, 1'b0, 3'd6, 3'd1, 16'h0F0F, 2, 16'h0, 16'h0};
    tab[8] = '{1'b1, 1'b1, 3'd6, 3'd5, 16'h0, 3, 16'h0F0F, 16'h1234};
    // reset values
    repeat (2) @(negedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rf_write", 32'(rf_write), 0);
    check("reset rf_readnum", 32'(rf_readnum), 0);
    check("reset rf_writenum", 32'(rf_writenum), 0);
    check("reset rf_data_in", 32'(rf_data_in), 0);
    check("reset rsp_a", 32'(rsp_a), 0);
    check("reset rsp_b", 32'(rsp_b), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) run(tab[i], $sformatf("v%0d", i));
    // contention from reset: grants alternate starting with port 0
    do_reset();
    drive(1'b0, 1'b1, 3'd3, 3'd5, 16'h0);
    drive(1'b1, 1'b1, 3'd5, 3'd3, 16'h0);
    g = 0;
    for (int i = 0; i < 100 && g < 6; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        seq[g] = req_ready;
        g++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("rr grant count", g, 6);
    for (int i = 0; i < g; i++) check($sformatf("rr grant %0d", i), 32'(seq[i]), (i % 2) ? 2 : 1);
    repeat (5) @(negedge clk);
    // simultaneous write(p0) and same-register read(p1)
    do_reset();
    drive(1'b0, 1'b0, 3'd7, 3'd0, 16'h00FF);
    drive(1'b1, 1'b1, 3'd7, 3'd7, 16'h0);
    #1;
    check("sim grant p0", 32'(req_ready), 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    check("sim rf_write", 32'(rf_write), 1);
    check("sim rf_writenum", 32'(rf_writenum), 7);
    check("sim busy ready", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    check("sim wr rsp_valid", 32'(rsp_valid), 1);
    check("sim wr rsp_port", 32'(rsp_port), 0);
    check("sim resp ready", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    check("sim grant p1", 32'(req_ready), 2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    wait_rsp(lat);
    check("sim rd latency", lat, SAME_LAT);
    check("sim rd rsp_port", 32'(rsp_port), 1);
    check("sim rd rsp_a", 32'(rsp_a), 16'h00FF);
    check("sim rd rsp_b", 32'(rsp_b), 16'h00FF);
    @(negedge clk);
    // reset during RD_B aborts the read
    drive(1'b0, 1'b1, 3'd3, 3'd5, 16'h0);
    wait_ready(1'b0, ok);
    check("abort ready", 32'(ok), 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    check("abort in RD_B", 32'(rf_readnum), 5);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check("abort rsp_valid", 32'(rsp_valid), 0);
    check("abort rf_readnum", 32'(rf_readnum), 0);
    check("abort rf_write", 32'(rf_write), 0);
    check("abort rsp_a", 32'(rsp_a), 0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("abort no late rsp", 32'(rsp_valid), 0);
    run('{1'b0, 1'b1, 3'd3, 3'd5, 16'h0, 3, 16'hBEEF, 16'h1234}, "reissue");
    // port 1 held valid during a port-0 read
    drive(1'b0, 1'b1, 3'd3, 3'd5, 16'h0);
    wait_ready(1'b0, ok);
    check("hold p0 ready", 32'(ok), 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drive(1'b1, 1'b1, 3'd5, 3'd3, 16'h0);
    pulses = 0;
    first = -1;
    rsps = 0;
    drop = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      if (req_ready[1]) begin
        pulses++;
        if (first < 0) first = i;
        drop = 1'b1;
      end
      if (rsp_valid) begin
        rsps++;
        if (rsp_port) check("hold p1 rsp_a", 32'(rsp_a), 16'h1234);
      end
      @(negedge clk);
      if (drop) req_valid[1] = 1'b0;
    end
    check("hold p1 first ready cycle", first, 4);
    check("hold p1 ready pulses", pulses, 1);
    check("hold responses", rsps, 2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rf_access_sched.md
# rf_access_sched

Sequencer and arbiter that shares the single-read-port, single-write-port 8×16 register file between two requesters: port 0 is the CPU controller and port 1 is the IO/debug path. It accepts whole transactions over a valid/ready handshake. A read-pair transaction (Ra, Rb) or a write transaction is serialized onto the register file's readnum/writenum/write pins. Results are returned on a shared one-cycle response strobe. It sits between the requesters and the register file and is the only block driving the register file's control inputs.

## Interface
- DW, 16, data width (must match register file)
- AW, 3, register index width (8 registers)
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req_valid[1:0]  in  2  per-port request valid
- req_ready[1:0]  out  2  per-port accept strobe; at most one bit set
- req_op[1:0]  in  2  per-port op: 1 = read pair, 0 = write
- req_ra0, req_ra1  in  AW  read index A (read op); write index (write op)
- req_rb0, req_rb1  in  AW  read index B (ignored for write)
- req_wdata0, req_wdata1  in  DW  write data (ignored for read)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_port  out  1  port that owns the response
- rsp_a, rsp_b  out  DW  read results; 0 for write completions
- rf_readnum  out  AW  to register file readnum
- rf_writenum  out  AW  to register file writenum
- rf_write  out  1  to register file write
- rf_data_in  out  DW  to register file data_in
- rf_data_out  in  DW  from register file data_out (combinational read)

## Operation
- FSM states: IDLE, RD_A, RD_B, WR, RESP.
- IDLE: arbitrate among asserted req_valid bits.
  - On a grant, pulse req_ready for the granted port in the same cycle.
  - Latch op, ra, rb, wdata and the port number.
  - Go to RD_A (read) or WR (write).
- Arbitration is round-robin with a one-bit last-grant pointer:
  - Both ports valid: the port not last granted wins.
  - Single valid port: that port wins unconditionally.
  - The pointer updates only on a grant.
  - Reset value of the pointer is 1, so port 0 wins the first contention.
- RD_A: rf_readnum = latched ra; capture rf_data_out into a_reg at the clock edge; go to RD_B.
- RD_B: rf_readnum = latched rb; capture into b_reg; go to RESP.
- WR: drive rf_write = 1, rf_writenum = latched ra, rf_data_in = latched wdata for exactly one cycle; a_reg and b_reg are cleared; go to RESP.
- RESP: rsp_valid = 1, rsp_port = latched port, rsp_a = a_reg, rsp_b = b_reg; go to IDLE.
- The response has no backpressure; requesters must accept rsp_valid unconditionally.
- Requesters hold valid and fields stable until ready is seen. Fields are sampled only in the ready cycle.
- Outside WR: rf_write = 0. rf_readnum, rf_writenum and rf_data_in are 0 when not in use.
- Read-after-write from the other port is naturally ordered, because transactions never overlap.

## Timing
- Reset (reset_n low at an edge) values:
  - state IDLE;
  - rsp_valid, req_ready, rf_write = 0;
  - all data and index outputs 0;
  - a_reg, b_reg = 0;
  - pointer = 1.
- Reset mid-transaction aborts it:
  - no response is issued;
  - a write in WR at the reset edge is not guaranteed to commit; the requester reissues.
- Read latency: accept at cycle T, RD_A at T+1, RD_B at T+2, rsp_valid at T+3; next accept no earlier than T+4.
- Write latency: accept at T, register file written at the end of T+1, rsp_valid at T+2; next accept no earlier than T+3.
- A request asserted during a busy state waits. req_ready is never asserted outside IDLE.

## Configuration
- RF_SCHED_SAMEREG_EN:
  - Defined: a read with ra == rb skips RD_B. RD_A captures into both a_reg and b_reg, then goes to RESP, so read latency drops to rsp_valid at T+2.
  - Undefined: every read visits RD_B (4-cycle turnaround), regardless of index equality.

## Structure
- Shared package rf_sched_pkg holds:
  - state enum (IDLE, RD_A, RD_B, WR, RESP);
  - op constants (OP_WRITE = 0, OP_READ = 1);
  - DW/AW defaults.
- Sub-module rr_arb2: the two-requester round-robin arbiter (req[1:0], advance, grant[1:0], pointer register, same clk/reset_n). It is instantiated once.

## Test plan
- Reset, then port 0 writes R3 = 16'hBEEF -> req_ready0 at T, rf_write=1/rf_writenum=3/rf_data_in=16'hBEEF at T+1, rsp_valid with rsp_port=0, rsp_a=rsp_b=0 at T+2.
- After R3 = 16'hBEEF and R5 = 16'h1234, port 1 reads (ra=3, rb=5) -> rsp_valid at T+3, rsp_port=1, rsp_a=16'hBEEF, rsp_b=16'h1234.
- Both ports valid continuously from reset -> grants alternate 0,1,0,1; never two consecutive grants to one port while both are valid.
- Port 0 writes R7 = 16'h00FF, with port 1 reading (7,7) requested in the same cycle -> port 0 granted first. Port 1 read returns 16'h00FF in both fields. With RF_SCHED_SAMEREG_EN, rsp_valid comes 2 cycles after its accept; without it, 3.
- reset_n driven low during RD_B -> next cycle in IDLE, no rsp_valid, outputs at reset values. A reissued read completes normally.
- req_valid1 held high during a port-0 read -> req_ready1 stays 0 until IDLE, then pulses exactly once.
